spi_byte_engine: RTL and testbench
==================================

// Module: spi_byte_engine
// PURPOSE
//  Hardware SPI mode-0 byte shifter placed directly downstream of the control-bit latch,
//  which writes the byte, and upstream of the SD/SPI pins SCK/MOSI/MISO.
//  Replaces per-bit software toggling of SCK/MOSI: one START shifts 8 bits MSB-first.
//  The received byte is held on RXDATA for the Gigatron bus read mux.
//  nSS stays owned by the control-bit latch; this block never drives it.
// PARAMETERS
//  DIV    2   SCK half-period in CLK cycles; legal range 1..255
//  CNTW   8   width of the half-period counter; must hold DIV-1
// PORTS
//  CLK      in   1  system clock; all state updates on posedge
//  nRESET   in   1  asynchronous, active-low reset
//  START    in   1  transfer request; sampled on posedge; honoured only when BUSY=0
//  TXDATA   in   8  byte to send; captured on the accepted START edge
//  MISO     in   1  serial data from the selected device
//  SCK      out  1  SPI clock, mode 0 (idle low)
//  MOSI     out  1  serial data to the device; idles high
//  RXDATA   out  8  last fully received byte; updated only at transfer end
//  BUSY     out  1  high while a transfer is in progress
//  DONE     out  1  one-CLK pulse in the cycle BUSY falls
// BEHAVIOUR
//  - All outputs are registered. Reset values: SCK=0, MOSI=1, RXDATA=8'h00, BUSY=0, DONE=0.
//    Reset also sets state=IDLE and clears both counters.
//  - States:
//    - IDLE: START=1 at edge E0 moves to LOW.
//      The E0 update loads tx<=TXDATA, sets MOSI=TXDATA[7], SCK=0, BUSY=1, hcnt=DIV-1, bit=0.
//    - LOW: while hcnt!=0, hcnt is decremented.
//      At hcnt=0: SCK<=1, rx<={rx[6:0],MISO}, hcnt<=DIV-1, state goes to HIGH.
//    - HIGH: while hcnt!=0, hcnt is decremented.
//      At hcnt=0 with bit<7: SCK<=0, MOSI<=next tx bit, bit++, hcnt<=DIV-1, state goes to LOW.
//      At hcnt=0 with bit=7: SCK<=0, MOSI<=1, BUSY<=0, DONE<=1, RXDATA<=rx.
//      This finishing update uses the rx value after the 8th sample. State returns to IDLE.
//  - Latency: the update at E0+16*DIV clears BUSY and sets DONE.
//    BUSY is therefore high for exactly 16*DIV cycles. Exactly 8 SCK rising edges occur.
//  - MISO is sampled in the same CLK edge that raises SCK (value held since the prior fall).
//  - MOSI changes only together with an SCK fall or at the start; it is stable across each SCK rise.
//  - START while BUSY=1 is ignored, not queued; TXDATA changes during a transfer have no effect.
//  - Back-to-back transfers: BUSY=0 is visible in the DONE cycle.
//    A START sampled at that edge is accepted, so the next transfer begins with no idle gap beyond one cycle.
//  - DONE is cleared on the cycle after it is set unless a new transfer ends there (impossible for DIV>=1).
//  - RXDATA holds between transfers. A partial byte never reaches RXDATA.
//  - Reset mid-transfer: outputs immediately return to reset values.
//    SCK drops asynchronously, no DONE is produced, and RXDATA reads 8'h00.
//  - DIV=1 is legal and gives SCK=CLK/2. hcnt never underflows because it is reloaded whenever it is 0.
// TESTING
//  1. DIV=2, TXDATA=8'hA5, MISO looped to MOSI, START pulse
//     -> SCK shows 8 pulses 2 cycles high; MOSI bits 1,0,1,0,0,1,0,1;
//        BUSY high 32 cycles; DONE one cycle; RXDATA=8'hA5.
//  2. DIV=1, TXDATA=8'hFF, MISO=0
//     -> BUSY high 16 cycles; RXDATA=8'h00; MOSI=1 throughout and after.
//  3. DIV=2, MISO driven 8'h3C, changed only on SCK falls; extra START pulses at cycles 5 and 20
//     -> those STARTs are ignored; a single transfer only; RXDATA=8'h3C.
//  4. DIV=3, START at 8'h81, nRESET low at cycle 20 for 2 cycles
//     -> SCK=0, MOSI=1, BUSY=0, RXDATA=8'h00 immediately.
//        No DONE is produced. A later START at 8'h81 completes normally after 48 cycles.
//  5. DIV=1, START held high continuously, TXDATA=8'h12 then 8'h34
//     -> transfers run back-to-back with new BUSY asserted on the cycle after DONE;
//        the second MOSI byte is 8'h34.

Source files
------------

// File: rtl/spi_byte_engine.sv
// ---------------------------------------------------------------------------
// spi_byte_engine
//
// Hardware SPI mode-0 byte shifter for the SD/SPI port. One accepted START
// shifts a byte out on MOSI, MSB first. At the same time it shifts a byte in
// from MISO. SCK idles low. MOSI idles high.
//
// The received byte appears on RXDATA only when all eight bits are in. It then
// stays there for the bus read mux until the next transfer completes. The
// device select line belongs to the control-bit latch and is not handled here.
//
// Parameters
//   DIV   SCK half-period in CLK cycles (1..255)
//   CNTW  width of the half-period counter; must be able to hold DIV-1
//
// Ports
//   CLK     in   system clock, all state changes on the rising edge
//   nRESET  in   asynchronous active-low reset
//   START   in   transfer request, honoured only while BUSY is low
//   TXDATA  in   byte to send, captured on the accepted START edge
//   MISO    in   serial data from the selected device
//   SCK     out  SPI clock, idle low
//   MOSI    out  serial data to the device, idle high
//   RXDATA  out  last fully received byte
//   BUSY    out  high while a transfer is running
//   DONE    out  one-cycle pulse in the cycle BUSY falls
// ---------------------------------------------------------------------------
module spi_byte_engine #(
    parameter int DIV  = 2,
    parameter int CNTW = 8
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       START,
    input  logic [7:0] TXDATA,
    input  logic       MISO,
    output logic       SCK,
    output logic       MOSI,
    output logic [7:0] RXDATA,
    output logic       BUSY,
    output logic       DONE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    // Each SCK phase counts down from this value to zero. Every phase
    // therefore lasts exactly DIV cycles. With DIV=1 the reload is zero, so
    // the counter is never decremented and cannot underflow.
    localparam logic [CNTW-1:0] RELOAD = CNTW'(DIV - 1);

    state_t          state, state_nxt;
    logic [CNTW-1:0] hcnt, hcnt_nxt;
    logic [2:0]      bitcnt, bitcnt_nxt;
    logic [7:0]      tx, tx_nxt;
    logic [7:0]      rx, rx_nxt;
    logic            sck_nxt;
    logic            mosi_nxt;
    logic [7:0]      rxdata_nxt;
    logic            busy_nxt;
    logic            done_nxt;

    // State and output register. All outputs come straight from flops.
    // Reset returns the pins to their idle levels at once, so a transfer cut
    // short by reset leaves SCK low without waiting for a clock.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state  <= IDLE;
            hcnt   <= '0;
            bitcnt <= '0;
            tx     <= '0;
            rx     <= '0;
            SCK    <= 1'b0;
            MOSI   <= 1'b1;
            RXDATA <= 8'h00;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            state  <= state_nxt;
            hcnt   <= hcnt_nxt;
            bitcnt <= bitcnt_nxt;
            tx     <= tx_nxt;
            rx     <= rx_nxt;
            SCK    <= sck_nxt;
            MOSI   <= mosi_nxt;
            RXDATA <= rxdata_nxt;
            BUSY   <= busy_nxt;
            DONE   <= done_nxt;
        end
    end

    // Next-state and next-output logic.
    //
    // tx is a left-shifting copy of the byte being sent. tx[7] is already on
    // MOSI, so on each SCK fall the next bit to present is tx[6]. MOSI only
    // changes at the start and on SCK falls, which keeps it stable across
    // every rising edge.
    //
    // MISO is sampled on the same edge that raises SCK. The device therefore
    // had the whole low half-period to settle its bit.
    //
    // DONE is a single-cycle pulse because it defaults to zero every cycle.
    always_comb begin
        state_nxt  = state;
        hcnt_nxt   = hcnt;
        bitcnt_nxt = bitcnt;
        tx_nxt     = tx;
        rx_nxt     = rx;
        sck_nxt    = SCK;
        mosi_nxt   = MOSI;
        rxdata_nxt = RXDATA;
        busy_nxt   = BUSY;
        done_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (START) begin
                    tx_nxt     = TXDATA;
                    mosi_nxt   = TXDATA[7];
                    sck_nxt    = 1'b0;
                    busy_nxt   = 1'b1;
                    hcnt_nxt   = RELOAD;
                    bitcnt_nxt = 3'd0;
                    state_nxt  = LOW;
                end
            end

            LOW: begin
                if (hcnt != '0) begin
                    hcnt_nxt = hcnt - CNTW'(1);
                end else begin
                    sck_nxt   = 1'b1;
                    rx_nxt    = {rx[6:0], MISO};
                    hcnt_nxt  = RELOAD;
                    state_nxt = HIGH;
                end
            end

            HIGH: begin
                if (hcnt != '0) begin
                    hcnt_nxt = hcnt - CNTW'(1);
                end else if (bitcnt != 3'd7) begin
                    sck_nxt    = 1'b0;
                    mosi_nxt   = tx[6];
                    tx_nxt     = {tx[6:0], 1'b0};
                    bitcnt_nxt = bitcnt + 3'd1;
                    hcnt_nxt   = RELOAD;
                    state_nxt  = LOW;
                end else begin
                    // rx already holds all eight samples here, because the
                    // last sample was taken on the preceding SCK rise.
                    sck_nxt    = 1'b0;
                    mosi_nxt   = 1'b1;
                    busy_nxt   = 1'b0;
                    done_nxt   = 1'b1;
                    rxdata_nxt = rx;
                    state_nxt  = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_byte_engine.sv
// ---------------------------------------------------------------------------
// tb_spi_byte_engine
//
// Drives three engines built with different dividers:
//   instance 0: DIV=2
//   instance 1: DIV=1
//   instance 2: DIV=3
//
// Every transfer is watched cycle by cycle and compared with the expected
// SPI mode-0 behaviour of one byte:
//   - BUSY lasts 16*DIV cycles.
//   - There are exactly eight SCK pulses, each DIV cycles high.
//   - The bits present on MOSI at the SCK rises spell the sent byte.
//   - MOSI only moves on an SCK fall.
//   - RXDATA equals the byte the device shifted in.
//   - DONE is a single pulse.
// ---------------------------------------------------------------------------
module tb_spi_byte_engine;

    logic       CLK;
    logic       nreset;
    logic [2:0] start;
    logic [2:0] miso;
    logic [7:0] txdata [3];
    wire  [2:0] sck;
    wire  [2:0] mosi;
    wire  [2:0] busy;
    wire  [2:0] done;
    wire  [23:0] rxflat;

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        spi_byte_engine #(
            .DIV  (g == 0 ? 2 : (g == 1 ? 1 : 3)),
            .CNTW (8)
        ) dut (
            .CLK    (CLK),
            .nRESET (nreset),
            .START  (start[g]),
            .TXDATA (txdata[g]),
            .MISO   (miso[g]),
            .SCK    (sck[g]),
            .MOSI   (mosi[g]),
            .RXDATA (rxflat[g*8 +: 8]),
            .BUSY   (busy[g]),
            .DONE   (done[g])
        );
    end

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic int divOf(input int s);
        return (s == 0) ? 2 : ((s == 1) ? 1 : 3);
    endfunction

    function automatic logic [7:0] rxOf(input int s);
        return rxflat[s*8 +: 8];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Runs one transfer on instance s and checks it against the expected
    // byte-level behaviour.
    //
    // If issue is set, START is raised first. Otherwise a START held from the
    // previous transfer is assumed to have been accepted already.
    //
    // If hold is set, START stays high through DONE and tNext is presented,
    // so the next transfer follows immediately.
    //
    // If loop is set, MISO follows MOSI. Otherwise the device sends m,
    // changing its bit only after each SCK fall.
    //
    // If noise is set, extra STARTs and a TXDATA change are injected mid-way.
    task automatic applyStimulus(input int s, input logic [7:0] t, input logic [7:0] m,
                                 input bit loop, input bit noise, input bit issue,
                                 input bit hold, input logic [7:0] tNext);
        int d;
        int busyCount;
        int rises;
        int highLen;
        int badHigh;
        int glitch;
        bit doneSeen;
        bit prevSck;
        bit prevMosi;
        logic [7:0] capt;

        d = divOf(s);
        if (issue) begin
            @(negedge CLK);
            txdata[s] = t;
            start[s]  = 1'b1;
            if (!loop) miso[s] = m[7];
        end
        @(negedge CLK);
        if (!hold) start[s] = 1'b0;
        checkOutput("busyRise", busy[s], 1);
        checkOutput("doneLowAtStart", done[s], 0);
        checkOutput("mosiFirstBit", mosi[s], t[7]);

        busyCount = 1;
        rises     = 0;
        highLen   = 0;
        badHigh   = 0;
        glitch    = 0;
        doneSeen  = 0;
        capt      = 8'h00;
        prevSck   = sck[s];
        prevMosi  = mosi[s];

        for (int cyc = 0; cyc < 16 * d + 8 && !doneSeen; cyc++) begin
            if (loop) miso[s] = mosi[s];
            if (noise && cyc + 2 < 16 * d) begin
                if (cyc == 4 || cyc == 19) start[s] = 1'b1;
                if (cyc == 5 || cyc == 20) start[s] = 1'b0;
                if (cyc == 7) txdata[s] = ~t;
            end
            @(negedge CLK);

            if (!prevSck && sck[s]) begin
                capt    = {capt[6:0], mosi[s]};
                rises++;
                highLen = 1;
            end else if (prevSck && sck[s]) begin
                highLen++;
            end

            if (prevSck && !sck[s]) begin
                if (highLen != d) badHigh++;
                if (!loop && rises < 8) miso[s] = m[7 - rises];
            end else if (mosi[s] != prevMosi && !done[s]) begin
                glitch++;
            end

            if (done[s]) doneSeen = 1;
            else if (busy[s]) busyCount++;
            prevSck  = sck[s];
            prevMosi = mosi[s];
        end

        checkOutput("doneSeen", doneSeen, 1);
        checkOutput("busyLowAtDone", busy[s], 0);
        checkOutput("busyCycles", busyCount, 16 * d);
        checkOutput("sckRises", rises, 8);
        checkOutput("sckHighWidthErrs", badHigh, 0);
        checkOutput("mosiGlitches", glitch, 0);
        checkOutput("mosiByte", capt, t);
        checkOutput("rxdata", rxOf(s), loop ? t : m);
        checkOutput("mosiIdle", mosi[s], 1);
        checkOutput("sckIdle", sck[s], 0);

        if (hold) begin
            txdata[s] = tNext;
        end else begin
            @(negedge CLK);
            checkOutput("donePulse", done[s], 0);
            checkOutput("busyIdle", busy[s], 0);
            checkOutput("rxHold", rxOf(s), loop ? t : m);
        end
    endtask

    initial begin
        logic [7:0] t;
        logic [7:0] m;
        int doneCount;
        bit sckWasHigh;

        nreset = 1'b0;
        start  = '0;
        miso   = '0;
        for (int i = 0; i < 3; i++) txdata[i] = 8'h00;
        repeat (3) @(negedge CLK);

        // Reset values.
        for (int s = 0; s < 3; s++) begin
            checkOutput("rstSck", sck[s], 0);
            checkOutput("rstMosi", mosi[s], 1);
            checkOutput("rstBusy", busy[s], 0);
            checkOutput("rstDone", done[s], 0);
            checkOutput("rstRx", rxOf(s), 8'h00);
        end
        nreset = 1'b1;
        @(negedge CLK);

        // DIV=2, loopback of A5.
        applyStimulus(0, 8'hA5, 8'h00, 1, 0, 1, 0, 8'h00);

        // DIV=1, all ones out, MISO held low.
        miso[1] = 1'b0;
        applyStimulus(1, 8'hFF, 8'h00, 0, 0, 1, 0, 8'h00);

        // DIV=2, device sends 3C, with stray STARTs and a TXDATA change mid-way.
        applyStimulus(0, 8'h5A, 8'h3C, 0, 1, 1, 0, 8'h00);

        // DIV=3, reset in the middle of a transfer while SCK is high.
        @(negedge CLK);
        txdata[2] = 8'h81;
        start[2]  = 1'b1;
        miso[2]   = 1'b1;
        @(negedge CLK);
        start[2] = 1'b0;
        for (int i = 0; i < 60 && sck[2] !== 1'b1; i++) @(negedge CLK);
        repeat (2) @(negedge CLK);
        sckWasHigh = sck[2];
        checkOutput("preResetSckHigh", sckWasHigh, 1);
        #2 nreset = 1'b0;
        #1;
        checkOutput("midRstSck", sck[2], 0);
        checkOutput("midRstMosi", mosi[2], 1);
        checkOutput("midRstBusy", busy[2], 0);
        checkOutput("midRstRx", rxOf(2), 8'h00);
        @(negedge CLK);
        @(negedge CLK);
        nreset = 1'b1;
        doneCount = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (done[2]) doneCount++;
        end
        checkOutput("noDoneAfterRst", doneCount, 0);
        checkOutput("busyAfterRst", busy[2], 0);
        applyStimulus(2, 8'h81, 8'hC3, 0, 0, 1, 0, 8'h00);

        // DIV=1, START held high: 12 then 34 run back-to-back.
        applyStimulus(1, 8'h12, 8'h00, 1, 0, 1, 1, 8'h34);
        applyStimulus(1, 8'h34, 8'h00, 1, 0, 0, 0, 8'h00);

        // Randomized transfers across all three dividers.
        for (int iter = 0; iter < 18; iter++) begin
            int s;
            bit lp;
            bit nz;
            s  = $urandom_range(0, 2);
            t  = 8'($urandom);
            m  = 8'($urandom);
            lp = 1'($urandom_range(0, 1));
            nz = 1'($urandom_range(0, 1));
            applyStimulus(s, t, m, lp, nz, 1, 0, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
